mux_rr_arb_16: RTL and testbench
================================

Name: mux_rr_arb_16

Overview:
- Round-robin burst arbiter that shares one 16:1 wide data mux (one-hot-free binary select) between 16 requesters.
- Each requester presents valid/data/last. The arbiter grants one requester for a whole burst and steers its data through the mux into a single registered output stage with valid/ready.
- Sits between 16 producer ports and one shared downstream consumer.

Parameters:
- DATA_W, 128, width of each requester data word and of out_data.
- N_REQ, 16, requester count (fixed at 16; select is 4 bits).
- CNT_W, 32, perf counter width (used only with the optional feature).

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  [0:15]  per-requester beat valid.
- in_data  input  [0:15][DATA_W-1:0]  per-requester beat data.
- in_last  input  [0:15]  final beat of a burst.
- in_ready  output  [0:15]  beat accepted when in_valid[i] && in_ready[i].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  DATA_W  registered muxed beat.
- out_last  output  1  registered last flag.
- out_src  output  4  index of the requester that supplied out_data.
- busy  output  1  high while in state BURST.

Behaviour:
- Reset: state=IDLE, ptr=0, grant=0. All outputs 0: out_valid, out_data, out_last, out_src, busy, in_ready.
- State IDLE:
  - If any in_valid is set, pick the first set index scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16 wrap).
  - Register it into grant and go to BURST.
  - This costs one arbitration bubble per burst; in_ready is all-zero in IDLE.
  - If no in_valid is set, stay in IDLE.
- State BURST:
  - in_ready[grant] = (!out_valid || out_ready). All other in_ready bits are 0.
  - On an accepted beat the output register loads in_data[grant], in_last[grant] and out_src=grant, and sets out_valid=1.
  - Latency is exactly 1 cycle from acceptance to out_valid.
  - If out_ready is high and no new beat is accepted, out_valid clears.
  - Output data is held stable while out_valid && !out_ready.
- Burst end: on an accepted beat with in_last[grant]=1, set ptr=(grant+1) mod 16 (15 wraps to 0) and return to IDLE.
- Requester valid dropping mid-burst: grant is held and the arbiter waits. There is no timeout and no re-arbitration before last.
- Single-beat burst (last on the first beat) is legal: 1 beat, then IDLE.
- The lone requester re-requests immediately: it wins again after the bubble, because the scan starts from ptr.
- Back-pressure: with out_ready=0 and out_valid=1, in_ready=0. No beat is lost or duplicated.
- Mux: data selection is the AND-OR of in_data[i] gated by (grant==i).
- Reset asserted mid-burst: asynchronous clear to the reset values. Any partially transferred burst is abandoned.

Optional Feature:
- Macro: MUX_RR_ARB_PERF_EN.
- When defined:
  - Adds input perf_sel [3:0] and output perf_cnt [CNT_W-1:0].
  - Keeps 16 counters, each counting accepted beats for its requester.
  - Counters saturate at all-ones and clear on reset.
  - perf_cnt = counter[perf_sel], combinational read.
- When undefined: no ports, no counters, identical datapath behaviour.

Decomposition:
- Package mux_rr_arb_pkg: N_REQ=16, SEL_W=4, typedef arb_state_e {IDLE, BURST}, typedef sel_t logic [3:0].
- One sub-module, rr_pick_16: purely combinational.
  - Inputs: 16-bit request vector and 4-bit ptr.
  - Outputs: found flag and 4-bit winning index.
- The top holds the FSM, the mux and the output register.

Test Plan:
- Reset: assert rst_n=0 mid-burst with requester 3 granted -> next edge out_valid=0, busy=0, in_ready=0; first arbitration after release starts at ptr=0.
- Fairness: in_valid=16'hFFFF, every burst 1 beat, out_ready=1 -> out_src sequence 0,1,2,...,15,0; one bubble cycle between beats.
- Burst hold: requester 5 sends a 4-beat burst while requester 2 requests -> out_src=5 for 4 beats with data order preserved; then src 2; ptr=6 after the 5 burst.
- Wrap: only requesters 15 and 0 active, ptr=15 -> grants 15, then 0, then 15.
- Back-pressure: out_ready=0 for 5 cycles during a burst -> out_data stable, in_ready=0, no beat dropped or duplicated on release.
- Perf (MUX_RR_ARB_PERF_EN): requester 7 sends 10 beats -> perf_sel=7 reads 10; perf_sel=8 reads 0.

Source files
------------

// File: rtl/mux_rr_arb_pkg.sv
// Shared types for the 16-port round-robin burst arbiter.
// Purely declarative: no logic, no latency, no flow control.
package mux_rr_arb_pkg;
    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_pick_16.sv
// Rotating priority pick: first set request scanning from ptr upward with wrap.
// Latency: combinational. Backpressure: none, pure function of inputs.
module rr_pick_16
    import mux_rr_arb_pkg::*;
(
    input  logic [15:0] req,
    input  sel_t        ptr,
    output logic        found,
    output sel_t        idx
);

    sel_t cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + sel_t'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arb_16.sv
// Round-robin burst arbiter sharing one 16:1 data mux into a registered valid/ready output stage.
// Latency: one bubble per burst for arbitration, then 1 cycle from accepted beat to out_valid.
// Backpressure: in_ready of the granted port follows (!out_valid || out_ready); optional perf counters via MUX_RR_ARB_PERF_EN.
module mux_rr_arb_16 #(
    parameter int DATA_W = 128,
    parameter int N_REQ  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [0:15]              in_valid,
    input  logic [0:15][DATA_W-1:0]  in_data,
    input  logic [0:15]              in_last,
    output logic [0:15]              in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [3:0]               out_src,
    output logic                     busy
`ifdef MUX_RR_ARB_PERF_EN
    ,
    input  logic [3:0]               perf_sel,
    output logic [CNT_W-1:0]         perf_cnt
`endif
);
    import mux_rr_arb_pkg::*;

    arb_state_e         state_q, state_d;
    sel_t               grant_q, grant_d;
    sel_t               ptr_q, ptr_d;
    logic [15:0]        req_vec;
    logic               pick_found;
    sel_t               pick_idx;
    logic               take;
    logic               accept;
    logic [DATA_W-1:0]  mux_data;
    logic               mux_last;

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_vec[i] = in_valid[i];
        end
    end

    rr_pick_16 u_pick (
        .req   (req_vec),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // The output stage can take a beat when it is empty or draining this cycle.
    assign take   = !out_valid || out_ready;
    assign accept = (state_q == BURST) && in_valid[grant_q] && take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (accept && in_last[grant_q]) begin
                    ptr_d   = grant_q + sel_t'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            in_ready[i] = (state_q == BURST) && (grant_q == sel_t'(i)) && take;
        end
        busy = (state_q == BURST);
    end

    always_comb begin
        mux_data = '0;
        mux_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            mux_data = mux_data | (in_data[i] & {DATA_W{grant_q == sel_t'(i)}});
            mux_last = mux_last | (in_last[i] & (grant_q == sel_t'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_last  <= mux_last;
            out_src   <= grant_q;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_RR_ARB_PERF_EN
    logic [CNT_W-1:0] perf_q [N_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                perf_q[i] <= '0;
            end
        end else if (accept && (perf_q[grant_q] != {CNT_W{1'b1}})) begin
            perf_q[grant_q] <= perf_q[grant_q] + 1'b1;
        end
    end

    assign perf_cnt = perf_q[perf_sel];
`endif

endmodule

// File: tb/tb_mux_rr_arb_16.sv
// Directed bench for mux_rr_arb_16: per-requester beat queues feed the DUT, output beats are logged.
module tb_mux_rr_arb_16;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 32;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [0:15]             in_valid;
    logic [0:15][DATA_W-1:0] in_data;
    logic [0:15]             in_last;
    logic [0:15]             in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic [3:0]              out_src;
    logic                    busy;
`ifdef MUX_RR_ARB_PERF_EN
    logic [3:0]              perf_sel;
    logic [CNT_W-1:0]        perf_cnt;
`endif

    mux_rr_arb_16 #(.DATA_W(DATA_W), .N_REQ(16), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .busy      (busy)
`ifdef MUX_RR_ARB_PERF_EN
        ,
        .perf_sel  (perf_sel),
        .perf_cnt  (perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        src;
        logic [DATA_W-1:0] data;
        logic              last;
        int                cyc;
    } obs_t;

    logic [DATA_W:0] mem [16][32];
    int              head [16];
    int              tail [16];
    logic            hold [16];
    logic            hs   [16];
    obs_t            obs_q [$];
    int              cyc;
    int              chk_cnt = 0;
    int              pass_cnt = 0;

    task automatic refresh();
        for (int i = 0; i < 16; i++) begin
            if (head[i] < tail[i]) begin
                in_valid[i] = !hold[i];
                in_data[i]  = mem[i][head[i]][DATA_W-1:0];
                in_last[i]  = mem[i][head[i]][DATA_W];
            end else begin
                in_valid[i] = 1'b0;
                in_data[i]  = '0;
                in_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [DATA_W-1:0] d, input logic l);
        mem[r][tail[r]] = {l, d};
        tail[r]++;
        refresh();
    endtask

    // Handshakes and output beats are sampled mid-cycle; producers advance just after the edge.
    task automatic tick();
        obs_t o;
        @(negedge clk);
        for (int i = 0; i < 16; i++) hs[i] = in_valid[i] && in_ready[i];
        if (out_valid && out_ready) begin
            o.src  = out_src;
            o.data = out_data;
            o.last = out_last;
            o.cyc  = cyc;
            obs_q.push_back(o);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 16; i++) if (hs[i]) head[i]++;
        refresh();
    endtask

    task automatic clear_bench();
        for (int i = 0; i < 16; i++) begin
            head[i] = 0;
            tail[i] = 0;
            hold[i] = 1'b0;
        end
        out_ready = 1'b1;
        refresh();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_bench();
        tick();
        tick();
        rst_n = 1'b1;
        obs_q.delete();
        cyc = 0;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk_cnt++;
        if (obs_q.size() >= n) pass_cnt++;
        else $display("FAIL %s: timeout with %0d beats, need %0d", name, obs_q.size(), n);
    endtask

    task automatic test_reset();
        int k;
        apply_reset();
        chk_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 16'h0)
            $display("FAIL reset_ctl: out_valid=%b busy=%b in_ready=%h, need 0/0/0000", out_valid, busy, in_ready);
        else pass_cnt++;
        chk_cnt++;
        if (out_data !== '0 || out_last !== 1'b0 || out_src !== 4'd0)
            $display("FAIL reset_dat: out_data=%h out_last=%b out_src=%0d, need 0", out_data, out_last, out_src);
        else pass_cnt++;

        // Move ptr to 6, then start a burst on requester 3 and reset in the middle of it.
        push(5, 'h55, 1'b1);
        run_until(1, 20, "reset_pre5");
        for (int b = 0; b < 4; b++) push(3, DATA_W'('h300 + b), (b == 3));
        k = 0;
        while (!(out_valid && out_src == 4'd3) && k < 20) begin
            tick();
            k++;
        end
        chk_cnt++;
        if (busy !== 1'b1 || out_src !== 4'd3)
            $display("FAIL reset_midburst_setup: busy=%b out_src=%0d, need 1/3", busy, out_src);
        else pass_cnt++;
        rst_n = 1'b0;
        #2;
        chk_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 16'h0)
            $display("FAIL reset_async: out_valid=%b busy=%b in_ready=%h, need 0/0/0000", out_valid, busy, in_ready);
        else pass_cnt++;
        clear_bench();
        tick();
        rst_n = 1'b1;
        obs_q.delete();
        push(15, 'hF5, 1'b1);
        push(2, 'h25, 1'b1);
        run_until(2, 20, "reset_rearb");
        chk_cnt++;
        if (obs_q.size() >= 2 && obs_q[0].src === 4'd2 && obs_q[1].src === 4'd15) pass_cnt++;
        else $display("FAIL reset_ptr: first src=%0d, need 2 then 15",
                      (obs_q.size() > 0) ? obs_q[0].src : 4'hx);
    endtask

    task automatic test_fairness();
        logic [3:0]        exp_src;
        logic [DATA_W-1:0] exp_dat;
        apply_reset();
        for (int i = 0; i < 16; i++) push(i, DATA_W'('hA00 + i), 1'b1);
        push(0, 'hA10, 1'b1);
        run_until(17, 200, "fair_run");
        for (int k = 0; k < 17 && k < obs_q.size(); k++) begin
            exp_src = (k < 16) ? 4'(k) : 4'd0;
            exp_dat = (k < 16) ? DATA_W'('hA00 + k) : DATA_W'('hA10);
            chk_cnt++;
            if (obs_q[k].src !== exp_src || obs_q[k].data !== exp_dat || obs_q[k].last !== 1'b1)
                $display("FAIL fair_beat%0d: src=%0d data=%h, need src=%0d data=%h",
                         k, obs_q[k].src, obs_q[k].data, exp_src, exp_dat);
            else pass_cnt++;
            if (k > 0) begin
                chk_cnt++;
                if (obs_q[k].cyc - obs_q[k-1].cyc !== 2)
                    $display("FAIL fair_gap%0d: spacing %0d cycles, need 2", k, obs_q[k].cyc - obs_q[k-1].cyc);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_burst_hold();
        logic [3:0]        exp_src [6];
        logic [DATA_W-1:0] exp_dat [6];
        logic              exp_lst [6];
        int k;
        exp_src = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd2, 4'd5};
        exp_dat = '{DATA_W'('h5000), DATA_W'('h5001), DATA_W'('h5002), DATA_W'('h5003),
                    DATA_W'('h2000), DATA_W'('h5100)};
        exp_lst = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        apply_reset();
        for (int b = 0; b < 4; b++) push(5, DATA_W'('h5000 + b), (b == 3));
        push(5, 'h5100, 1'b1);
        k = 0;
        while (!busy && k < 10) begin
            tick();
            k++;
        end
        push(2, 'h2000, 1'b1);
        run_until(1, 20, "hold_first");
        // Requester 5 goes quiet mid-burst; requester 2 must not steal the grant.
        hold[5] = 1'b1;
        refresh();
        repeat (4) tick();
        chk_cnt++;
        if (busy !== 1'b1 || in_ready[2] !== 1'b0 || obs_q.size() !== 2)
            $display("FAIL hold_gap: busy=%b in_ready2=%b beats=%0d, need 1/0/2", busy, in_ready[2], obs_q.size());
        else pass_cnt++;
        hold[5] = 1'b0;
        refresh();
        run_until(6, 60, "hold_run");
        for (int j = 0; j < 6 && j < obs_q.size(); j++) begin
            chk_cnt++;
            if (obs_q[j].src !== exp_src[j] || obs_q[j].data !== exp_dat[j] || obs_q[j].last !== exp_lst[j])
                $display("FAIL hold_beat%0d: src=%0d data=%h last=%b, need src=%0d data=%h last=%b",
                         j, obs_q[j].src, obs_q[j].data, obs_q[j].last, exp_src[j], exp_dat[j], exp_lst[j]);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_src [4];
        exp_src = '{4'd14, 4'd15, 4'd0, 4'd15};
        apply_reset();
        push(14, 'hE0, 1'b1);
        run_until(1, 20, "wrap_pre");
        push(15, 'hF0, 1'b1);
        push(15, 'hF1, 1'b1);
        push(0, 'h0A, 1'b1);
        run_until(4, 60, "wrap_run");
        for (int j = 0; j < 4 && j < obs_q.size(); j++) begin
            chk_cnt++;
            if (obs_q[j].src !== exp_src[j])
                $display("FAIL wrap_beat%0d: src=%0d, need %0d", j, obs_q[j].src, exp_src[j]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] held;
        int k;
        apply_reset();
        for (int b = 0; b < 4; b++) push(9, DATA_W'('h9000 + b), (b == 3));
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        out_ready = 1'b0;
        held = out_data;
        chk_cnt++;
        if (held !== DATA_W'('h9000)) $display("FAIL bp_first: out_data=%h, need 9000", held);
        else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_cnt++;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 16'h0)
                $display("FAIL bp_stall%0d: out_valid=%b out_data=%h in_ready=%h, need 1/%h/0000",
                         c, out_valid, out_data, in_ready, held);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        run_until(4, 40, "bp_run");
        repeat (6) tick();
        chk_cnt++;
        if (obs_q.size() !== 4) $display("FAIL bp_count: %0d beats, need 4", obs_q.size());
        else pass_cnt++;
        for (int j = 0; j < 4 && j < obs_q.size(); j++) begin
            chk_cnt++;
            if (obs_q[j].src !== 4'd9 || obs_q[j].data !== DATA_W'('h9000 + j))
                $display("FAIL bp_beat%0d: src=%0d data=%h, need src=9 data=%h",
                         j, obs_q[j].src, obs_q[j].data, DATA_W'('h9000 + j));
            else pass_cnt++;
        end
    endtask

`ifdef MUX_RR_ARB_PERF_EN
    task automatic test_perf();
        apply_reset();
        for (int b = 0; b < 10; b++) push(7, DATA_W'('h7000 + b), (b == 9));
        run_until(10, 80, "perf_run");
        perf_sel = 4'd7;
        #1;
        chk_cnt++;
        if (perf_cnt !== CNT_W'(10)) $display("FAIL perf_7: perf_cnt=%0d, need 10", perf_cnt);
        else pass_cnt++;
        perf_sel = 4'd8;
        #1;
        chk_cnt++;
        if (perf_cnt !== CNT_W'(0)) $display("FAIL perf_8: perf_cnt=%0d, need 0", perf_cnt);
        else pass_cnt++;
    endtask
`endif

    initial begin
        cyc = 0;
        in_valid = '0;
        in_data = '0;
        in_last = '0;
        out_ready = 1'b1;
`ifdef MUX_RR_ARB_PERF_EN
        perf_sel = 4'd0;
`endif
        test_reset();
        test_fairness();
        test_burst_hold();
        test_wrap();
        test_backpressure();
`ifdef MUX_RR_ARB_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
